// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM encoding and immediate decoders for the instruction fetch unit.
// Used by fetch_unit and, when FETCH_BHT_EN is defined, fetch_bht.
package fetch_unit_pkg;

  localparam int unsigned XLen = 32;
  localparam int unsigned ILen = 32;

  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {
    StFetch,
    StMemWait,
    StHold,
    StDrop
  } fetch_state_e;

  function automatic logic [XLen-1:0] imm_j(input logic [ILen-1:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [XLen-1:0] imm_b(input logic [ILen-1:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table of 2-bit saturating counters, one per pc[BHT_IDX_W+1:2].
// Reads are combinational, so a same-cycle update is seen only on the next read.
module fetch_bht
  import fetch_unit_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic [XLen-1:0] rd_pc,
  output logic            rd_taken,
  input  logic            upd_valid,
  input  logic [XLen-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam int unsigned Entries = 1 << BHT_IDX_W;

  logic [1:0]           ctr_q [Entries];
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [1:0]           upd_old;
  logic [1:0]           upd_new;

  assign rd_idx   = rd_pc[BHT_IDX_W+1:2];
  assign upd_idx  = upd_pc[BHT_IDX_W+1:2];
  assign rd_taken = ctr_q[rd_idx][1];

  always_comb begin
    upd_old = ctr_q[upd_idx];
    upd_new = upd_old;
    if (upd_taken && (upd_old != 2'b11)) begin
      upd_new = upd_old + 2'd1;
    end else if (!upd_taken && (upd_old != 2'b00)) begin
      upd_new = upd_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else if (rdy && upd_valid) begin
      ctr_q[upd_idx] <= upd_new;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[XLen-1:BHT_IDX_W+2], rd_pc[1:0],
                            upd_pc[XLen-1:BHT_IDX_W+2], upd_pc[1:0]};

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry buffer and next-PC prediction.
// Define FETCH_BHT_EN to add counter-based branch prediction; otherwise only JAL is taken.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLen-1:0] RESET_PC  = 32'h0,
  parameter int unsigned     BHT_IDX_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            disp_req,
  output logic            ins_valid,
  output logic [XLen-1:0] ins_pc,
  output logic [ILen-1:0] ins_code,
  output logic [XLen-1:0] ins_pred_pc,
  output logic            ins_pred_taken,
  output logic            mem_req,
  output logic [XLen-1:0] mem_addr,
  input  logic            mem_done,
  input  logic [ILen-1:0] mem_data,
  input  logic            redirect,
  input  logic [XLen-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLen-1:0] upd_pc,
  input  logic            upd_taken
);

  fetch_state_e    state_q;
  logic [XLen-1:0] pc_q;
  logic            buf_valid_q;
  logic [XLen-1:0] buf_pc_q;
  logic [ILen-1:0] buf_code_q;
  logic [XLen-1:0] buf_pred_pc_q;
  logic            buf_pred_taken_q;

  logic            br_taken;
  logic [XLen-1:0] pred_pc;
  logic            pred_taken;

`ifdef FETCH_BHT_EN
  fetch_bht #(
    .BHT_IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rd_pc    (pc_q),
    .rd_taken (br_taken),
    .upd_valid(upd_valid),
    .upd_pc   (upd_pc),
    .upd_taken(upd_taken)
  );
`else
  assign br_taken = 1'b0;

  logic unused_upd;
  assign unused_upd = (^{upd_valid, upd_pc, upd_taken}) ^ (BHT_IDX_W == 0);
`endif

  // Prediction for the word arriving now; pc_q still holds its fetch address.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_q + 32'd4;
    if (mem_data[6:0] == OpcJal) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + imm_j(mem_data);
    end else if ((mem_data[6:0] == OpcBranch) && br_taken) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + imm_b(mem_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StFetch;
      pc_q             <= RESET_PC;
      mem_req          <= 1'b0;
      mem_addr         <= RESET_PC;
      buf_valid_q      <= 1'b0;
      buf_pc_q         <= '0;
      buf_code_q       <= '0;
      buf_pred_pc_q    <= '0;
      buf_pred_taken_q <= 1'b0;
      ins_valid        <= 1'b0;
      ins_pc           <= '0;
      ins_code         <= '0;
      ins_pred_pc      <= '0;
      ins_pred_taken   <= 1'b0;
    end else if (rdy) begin
      ins_valid <= 1'b0;
      unique case (state_q)
        StFetch: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= pc_q;
            state_q  <= StMemWait;
          end
        end
        StMemWait: begin
          if (redirect) begin
            pc_q <= redirect_pc;
            if (mem_done) begin
              mem_req <= 1'b0;
              state_q <= StFetch;
            end else begin
              state_q <= StDrop;
            end
          end else if (mem_done) begin
            mem_req          <= 1'b0;
            buf_valid_q      <= 1'b1;
            buf_pc_q         <= pc_q;
            buf_code_q       <= mem_data;
            buf_pred_pc_q    <= pred_pc;
            buf_pred_taken_q <= pred_taken;
            state_q          <= StHold;
          end
        end
        StHold: begin
          if (redirect) begin
            pc_q        <= redirect_pc;
            buf_valid_q <= 1'b0;
            state_q     <= StFetch;
          end else if (disp_req && buf_valid_q) begin
            ins_valid      <= 1'b1;
            ins_pc         <= buf_pc_q;
            ins_code       <= buf_code_q;
            ins_pred_pc    <= buf_pred_pc_q;
            ins_pred_taken <= buf_pred_taken_q;
            pc_q           <= buf_pred_pc_q;
            buf_valid_q    <= 1'b0;
            state_q        <= StFetch;
          end
        end
        StDrop: begin
          // The request is still outstanding; its response belongs to the old path.
          if (redirect) begin
            pc_q <= redirect_pc;
          end
          if (mem_done) begin
            mem_req <= 1'b0;
            state_q <= StFetch;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked against a
// transaction-level model of the instruction stream, memory side and predictor.
module tb_fetch_unit;

  localparam int unsigned IdxW    = 8;
  localparam logic [31:0] ResetPc = 32'h0;

  logic        clk = 1'b0;
  logic        rst, rdy, disp_req, ins_valid, ins_pred_taken;
  logic [31:0] ins_pc, ins_code, ins_pred_pc;
  logic        mem_req, mem_done;
  logic [31:0] mem_addr, mem_data;
  logic        redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc;

  fetch_unit #(
    .RESET_PC (ResetPc),
    .BHT_IDX_W(IdxW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .disp_req      (disp_req),
    .ins_valid     (ins_valid),
    .ins_pc        (ins_pc),
    .ins_code      (ins_code),
    .ins_pred_pc   (ins_pred_pc),
    .ins_pred_taken(ins_pred_taken),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_done      (mem_done),
    .mem_data      (mem_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model state: what the next fetch address must be, the outstanding memory
  // transaction, the word waiting for dispatch and the delivery expected now.
  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] exp_pc, req_addr, b_pc, b_code, b_pred, e_pc, e_code, e_pred, last_pc;
  bit          mem_busy, mem_stale, buf_full, b_taken, exp_valid, e_taken, just_done, junk_done;
  int          mem_wait;
  int          lat_force = -1;
  int          idle;
`ifdef FETCH_BHT_EN
  int          ctr [256];
`endif

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    logic [31:0] w;
    if (mem_img.exists(a)) return mem_img[a];
    h = (a ^ 32'h5bd1e995) * 32'h9e3779b1;
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd0:       w = {h[31:7], 7'b1101111};
      3'd1, 3'd2: w = {h[31:7], 7'b1100011};
      3'd3:       w = {h[31:7], 7'b1100111};
      3'd4:       w = {h[31:7], 7'b0010011};
      default:    w = h;
    endcase
    return w;
  endfunction

  function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                  output logic [31:0] npc, output bit tk);
    int off;
    tk  = 1'b0;
    npc = pc + 32'd4;
    if (w[6:0] == 7'b1101111) begin
      off = int'({w[31], w[19:12], w[20], w[30:21], 1'b0});
      if (w[31]) off = off - (1 << 21);
      tk  = 1'b1;
      npc = pc + off;
    end
`ifdef FETCH_BHT_EN
    else if (w[6:0] == 7'b1100011 && ctr[(pc >> 2) % 256] >= 2) begin
      off = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      if (w[31]) off = off - (1 << 13);
      tk  = 1'b1;
      npc = pc + off;
    end
`endif
  endfunction

  task automatic observe();
    check("ins_valid", ins_valid, exp_valid);
    if (exp_valid) begin
      check("ins_pc", ins_pc, e_pc);
      check("ins_code", ins_code, e_code);
      check("ins_pred_pc", ins_pred_pc, e_pred);
      check("ins_pred_taken", ins_pred_taken, e_taken);
    end
    if (mem_busy) begin
      check("mem_req_held", mem_req, 1);
      check("mem_addr_held", mem_addr, req_addr);
    end else if (just_done) begin
      check("mem_req_drop", mem_req, 0);
    end else if (mem_req) begin
      check("fetch_addr", mem_addr, exp_pc);
      mem_busy  = 1'b1;
      mem_stale = 1'b0;
      req_addr  = exp_pc;
      mem_wait  = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
    end
    just_done = 1'b0;
  endtask

  task automatic step(input bit d, input bit r, input logic [31:0] rpc, input bit uv,
                      input logic [31:0] upc, input bit ut, input bit rd);
    bit          done;
    bit          tk;
    logic [31:0] npc;
    observe();
    done = 1'b0;
    if (mem_busy && rd) begin
      if (mem_wait == 0) done = 1'b1;
      else mem_wait--;
    end
    rdy         = rd;
    disp_req    = d;
    redirect    = r;
    redirect_pc = rpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    mem_done    = done || (junk_done && !mem_busy);
    junk_done   = 1'b0;
    mem_data    = done ? word_at(req_addr) : $urandom();
    if (rd) begin
      exp_valid = 1'b0;
      if (r) begin
        if (done) mem_busy = 1'b0;
        else if (mem_busy) mem_stale = 1'b1;
        buf_full = 1'b0;
        exp_pc   = rpc;
      end else begin
        if (buf_full && d) begin
          exp_valid = 1'b1;
          e_pc      = b_pc;
          e_code    = b_code;
          e_pred    = b_pred;
          e_taken   = b_taken;
          last_pc   = b_pc;
          exp_pc    = b_pred;
          buf_full  = 1'b0;
        end
        if (done) begin
          mem_busy = 1'b0;
          if (!mem_stale) begin
            predict(req_addr, mem_data, npc, tk);
            buf_full = 1'b1;
            b_pc     = req_addr;
            b_code   = mem_data;
            b_pred   = npc;
            b_taken  = tk;
          end
        end
      end
      if (done) just_done = 1'b1;
`ifdef FETCH_BHT_EN
      if (uv) begin
        if (ut && ctr[(upc >> 2) % 256] < 3) ctr[(upc >> 2) % 256]++;
        if (!ut && ctr[(upc >> 2) % 256] > 0) ctr[(upc >> 2) % 256]--;
      end
`endif
    end
    if (mem_busy || buf_full || r) idle = 0;
    else if (rd) idle++;
    check("fetch_live", 32'(idle > 3), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    rdy         = 1'($urandom_range(0, 1));
    redirect    = 1'b1;
    redirect_pc = 32'hdeadbeec;
    upd_valid   = 1'b1;
    upd_pc      = 32'h0;
    upd_taken   = 1'b0;
    disp_req    = 1'b1;
    mem_done    = 1'b1;
    mem_data    = $urandom();
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_ins_pc", ins_pc, 0);
    check("rst_ins_code", ins_code, 0);
    check("rst_ins_pred_pc", ins_pred_pc, 0);
    check("rst_ins_pred_taken", ins_pred_taken, 0);
    rst       = 1'b0;
    redirect  = 1'b0;
    upd_valid = 1'b0;
    mem_done  = 1'b0;
    exp_pc    = ResetPc;
    mem_busy  = 1'b0;
    mem_stale = 1'b0;
    buf_full  = 1'b0;
    exp_valid = 1'b0;
    just_done = 1'b0;
    junk_done = 1'b1;
    idle      = 0;
    last_pc   = ResetPc;
`ifdef FETCH_BHT_EN
    for (int i = 0; i < 256; i++) ctr[i] = 1;
`endif
  endtask

  task automatic deliver_one(input logic [31:0] pc_e, input logic [31:0] pred_e, input bit tk_e);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(1, 0, 0, 0, 0, 0, 1);
      got = ins_valid;
    end
    check("deliver_seen", got, 1);
    check("deliver_pc", ins_pc, pc_e);
    check("deliver_pred_pc", ins_pred_pc, pred_e);
    check("deliver_pred_taken", ins_pred_taken, tk_e);
  endtask

  task automatic next_fetch(input logic [31:0] a, input bit d);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = mem_req && !mem_busy;
      if (!got) step(d, 0, 0, 0, 0, 0, 1);
    end
    check("next_fetch_seen", got, 1);
    check("next_fetch_addr", mem_addr, a);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] upc;
    mem_img[32'h0]  = 32'h00500093;
    mem_img[32'h10] = 32'h0080006f;
    mem_img[32'h20] = 32'h00000863;
    do_reset();

    // addi at the reset PC, three-cycle memory latency.
    lat_force = 2;
    deliver_one(32'h0, 32'h4, 1'b0);
    lat_force = -1;
    next_fetch(32'h4, 1'b0);

    // jal x0,8 at 0x10 after redirecting away from the in-flight fetch at 0x4.
    step(0, 1, 32'h10, 0, 0, 0, 1);
    deliver_one(32'h10, 32'h18, 1'b1);
    next_fetch(32'h18, 1'b0);

    // Redirect while waiting on 0x8: stale word must not be dispatched.
    step(0, 1, 32'h8, 0, 0, 0, 1);
    lat_force = 6;
    next_fetch(32'h8, 1'b0);
    step(1, 1, 32'h100, 0, 0, 0, 1);
    lat_force = -1;
    next_fetch(32'h100, 1'b1);

    // Buffered word held without dispatch, then redirect beats the dispatch request.
    lat_force = 0;
    repeat (14) step(0, 0, 0, 0, 0, 0, 1);
    lat_force = -1;
    step(1, 1, 32'h200, 0, 0, 0, 1);
    next_fetch(32'h200, 1'b0);

    // Train the counter at 0x20 then fetch beq +16 there.
    repeat (3) step(0, 0, 0, 1, 32'h20, 1, 1);
    step(0, 1, 32'h20, 0, 0, 0, 1);
`ifdef FETCH_BHT_EN
    deliver_one(32'h20, 32'h30, 1'b1);
`else
    deliver_one(32'h20, 32'h24, 1'b0);
`endif

    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset();
      rpc = 32'($urandom_range(0, 255)) << 2;
      upc = ($urandom_range(0, 1) == 1) ? last_pc : (32'($urandom_range(0, 255)) << 2);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc,
           $urandom_range(0, 2) == 0, upc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
